pos_sweep: RTL and testbench
============================

POS_SWEEP -- requirements
Module: pos_sweep

Interface
REQ-001 SHALL have parameter N, default 3, meaning the number of function inputs (X,Y,Z,... with MSB = X), legal 2..8.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, request to begin one sweep; sampled in IDLE only.
REQ-005 SHALL have port mask_a, input, 2**N, maxterm list of function A; bit i = 1 means maxterm M(i) is present.
REQ-006 SHALL have port mask_b, input, 2**N, maxterm list of function B, same encoding.
REQ-007 SHALL have port out_ready, input, 1, consumer ready for the current row.
REQ-008 SHALL have port busy, output, 1, high in SWEEP and DONE.
REQ-009 SHALL have port row_valid, output, 1, the current row is presented.
REQ-010 SHALL have port row_idx, output, N, input combination of the current row.
REQ-011 SHALL have port row_sa, output, 1, PoS(mask_a) evaluated at row_idx.
REQ-012 SHALL have port row_sb, output, 1, PoS(mask_b) evaluated at row_idx.
REQ-013 SHALL have port done, output, 1, single-cycle pulse at the end of the sweep.
REQ-014 SHALL have port equal, output, 1, A and B agreed on every row of the last sweep.
REQ-015 SHALL have port mismatch_count, output, N+1, number of rows where row_sa != row_sb.
REQ-016 SHALL have port first_mismatch, output, N, lowest row_idx with a disagreement; 0 if none.

Function
REQ-017 SHALL evaluate each function as a product of sums: output 0 exactly at indices whose mask bit is 1, otherwise 1.
REQ-018 SHALL implement a 3-state FSM: IDLE, SWEEP, DONE.
REQ-019 SHALL, in IDLE with start=1, latch mask_a/mask_b, clear row_idx, mismatch_count and the mismatch flag, and enter SWEEP on the next edge.
REQ-020 SHALL ignore mask_a/mask_b changes after latching until the next accepted start.
REQ-021 SHALL hold row_valid=1 throughout SWEEP, with row_sa/row_sb combinationally consistent with row_idx and the latched masks.
REQ-022 SHALL accept a row only on the cycle where row_valid && out_ready; then it updates the statistics and increments row_idx.
REQ-023 SHALL hold row_idx, row_sa and row_sb stable while out_ready=0, with no limit on stall length.
REQ-024 SHALL, on acceptance of row 2**N-1, move to DONE without wrapping row_idx past the sweep end.
REQ-025 SHALL, in DONE, pulse done for exactly one cycle, drive row_valid=0, and return to IDLE.
REQ-026 SHALL make equal, mismatch_count and first_mismatch final on the done cycle and hold them until the next accepted start.
REQ-027 SHALL record first_mismatch only on the first disagreeing accepted row; later disagreements do not change it.
REQ-028 SHALL size mismatch_count to N+1 bits so that a full 2**N mismatch cannot overflow.
REQ-029 SHALL ignore start while busy=1; a start coincident with the done pulse is also ignored.

Reset
REQ-030 SHALL, on rst_n=0, immediately enter IDLE with busy=0, row_valid=0, done=0, row_idx=0, mismatch_count=0, first_mismatch=0, equal=1 and latched masks=0.
REQ-031 SHALL abort a sweep in progress on reset, with no done pulse produced.
REQ-032 SHALL take no start earlier than the first rising clk after rst_n rises.

Structure
REQ-033 SHALL place the FSM state enum (IDLE, SWEEP, DONE) and the N legality bounds in shared package pos_pkg.
REQ-034 SHALL use one combinational sub-module pos_eval (parameter N; inputs mask, idx; output s) instantiated twice, for A and B.
REQ-035 SHALL place all sequential logic in pos_sweep; pos_eval is purely combinational.

Verification
REQ-036 SHALL cover: N=3, mask_a=mask_b=8'b0100_1110 (M 1,2,3,6), out_ready=1 -> row_sa for idx 0..7 = 1,0,0,0,1,1,0,1; done after 8 accepts; equal=1, count=0.
REQ-037 SHALL cover: N=3, mask_a=8'b0100_1110, mask_b=8'b0100_1100 -> mismatch at idx 1 only; count=1, first_mismatch=1, equal=0.
REQ-038 SHALL cover: out_ready low for 3 cycles while at idx 2 -> row_idx stays 2 and row_sa stays 0; the sweep completes with unchanged results.
REQ-039 SHALL cover: rst_n low at idx 4 -> all outputs at reset values at once; no done pulse; a new start gives a full clean sweep.
REQ-040 SHALL cover: start pulsed mid-sweep with different masks -> ignored; results reflect the original masks.
REQ-041 SHALL cover: N=4, mask_a=16'hFFFF, mask_b=16'h0000 -> count=16 (5'b10000), first_mismatch=0, equal=0.

Source files
------------

// File: rtl/pos_pkg.sv
// Shared FSM state encoding and the legal range of the input count N
// for the product-of-sums sweep block.
package pos_pkg;

  localparam int N_MIN = 2;
  localparam int N_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/pos_eval.sv
// Product-of-sums evaluator: a maxterm list drives the function to 0 exactly
// at the listed input combinations and to 1 everywhere else.
module pos_eval #(
  parameter int N = 3
) (
  input  logic [2**N-1:0] mask,
  input  logic [N-1:0]    idx,
  output logic            s
);

  assign s = ~mask[idx];

endmodule

// File: rtl/pos_sweep.sv
// Walks every input combination of two PoS functions, presenting one row per
// handshake, and reports whether and where the two functions disagree.
module pos_sweep
  import pos_pkg::*;
#(
  parameter int N = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [2**N-1:0] mask_a,
  input  logic [2**N-1:0] mask_b,
  input  logic          out_ready,
  output logic          busy,
  output logic          row_valid,
  output logic [N-1:0]  row_idx,
  output logic          row_sa,
  output logic          row_sb,
  output logic          done,
  output logic          equal,
  output logic [N:0]    mismatch_count,
  output logic [N-1:0]  first_mismatch
);

  localparam int ROWS = 2**N;

  if (N < N_MIN || N > N_MAX) begin : g_bad_n
    $error("pos_sweep: N out of legal range");
  end

  state_e          state_q, state_d;
  logic [ROWS-1:0] mask_a_q, mask_a_d;
  logic [ROWS-1:0] mask_b_q, mask_b_d;
  logic [N-1:0]    row_idx_q, row_idx_d;
  logic [N-1:0]    first_q, first_d;
  logic [N:0]      count_q, count_d;
  logic            seen_q, seen_d;
  logic            sa, sb;

  pos_eval #(.N(N)) u_eval_a (.mask(mask_a_q), .idx(row_idx_q), .s(sa));
  pos_eval #(.N(N)) u_eval_b (.mask(mask_b_q), .idx(row_idx_q), .s(sb));

  always_comb begin
    state_d   = state_q;
    mask_a_d  = mask_a_q;
    mask_b_d  = mask_b_q;
    row_idx_d = row_idx_q;
    first_d   = first_q;
    count_d   = count_q;
    seen_d    = seen_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_a_d  = mask_a;
          mask_b_d  = mask_b;
          row_idx_d = '0;
          first_d   = '0;
          count_d   = '0;
          seen_d    = 1'b0;
          state_d   = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        if (out_ready) begin
          if (sa != sb) begin
            count_d = count_q + {{N{1'b0}}, 1'b1};
            // Only the first disagreeing row is remembered.
            if (!seen_q) begin
              first_d = row_idx_q;
              seen_d  = 1'b1;
            end
          end
          // The last row leaves row_idx parked at the top instead of wrapping.
          if (row_idx_q == {N{1'b1}}) begin
            state_d = ST_DONE;
          end else begin
            row_idx_d = row_idx_q + {{(N-1){1'b0}}, 1'b1};
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mask_a_q  <= '0;
      mask_b_q  <= '0;
      row_idx_q <= '0;
      first_q   <= '0;
      count_q   <= '0;
      seen_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_a_q  <= mask_a_d;
      mask_b_q  <= mask_b_d;
      row_idx_q <= row_idx_d;
      first_q   <= first_d;
      count_q   <= count_d;
      seen_q    <= seen_d;
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign row_valid      = (state_q == ST_SWEEP);
  assign done           = (state_q == ST_DONE);
  assign row_idx        = row_idx_q;
  assign row_sa         = sa;
  assign row_sb         = sb;
  assign equal          = ~seen_q;
  assign mismatch_count = count_q;
  assign first_mismatch = first_q;

endmodule

// File: tb/tb_pos_sweep.sv
// Scoreboard bench for pos_sweep: stimulus queues hand-computed rows and
// results, a negedge monitor pops and compares on each accepted row and done.
module tb_pos_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, out_ready;
  logic [7:0] mask_a, mask_b;
  logic       busy, row_valid, row_sa, row_sb, done, equal;
  logic [2:0] row_idx, first_mismatch;
  logic [3:0] mismatch_count;

  logic        start4, out_ready4;
  logic [15:0] mask_a4, mask_b4;
  logic        busy4, row_valid4, row_sa4, row_sb4, done4, equal4;
  logic [3:0]  row_idx4, first_mismatch4;
  logic [4:0]  mismatch_count4;

  pos_sweep #(.N(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mask_a(mask_a), .mask_b(mask_b),
    .out_ready(out_ready), .busy(busy), .row_valid(row_valid), .row_idx(row_idx),
    .row_sa(row_sa), .row_sb(row_sb), .done(done), .equal(equal),
    .mismatch_count(mismatch_count), .first_mismatch(first_mismatch)
  );

  pos_sweep #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .mask_a(mask_a4), .mask_b(mask_b4),
    .out_ready(out_ready4), .busy(busy4), .row_valid(row_valid4), .row_idx(row_idx4),
    .row_sa(row_sa4), .row_sb(row_sb4), .done(done4), .equal(equal4),
    .mismatch_count(mismatch_count4), .first_mismatch(first_mismatch4)
  );

  typedef struct {logic [2:0] idx; logic sa; logic sb;} row_t;
  typedef struct {logic eq; logic [3:0] cnt; logic [2:0] first;} res_t;

  row_t row_q[$];
  res_t res_q[$];
  row_t mon_r;
  res_t mon_s;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] sa_bits, input logic [7:0] sb_bits,
                          input logic eq, input logic [3:0] cnt, input logic [2:0] first);
    row_t r;
    res_t s;
    for (int i = 0; i < 8; i++) begin
      r.idx = 3'(i);
      r.sa  = sa_bits[i];
      r.sb  = sb_bits[i];
      row_q.push_back(r);
    end
    s.eq = eq;
    s.cnt = cnt;
    s.first = first;
    res_q.push_back(s);
  endtask

  task automatic start_sweep(input logic [7:0] ma, input logic [7:0] mb);
    @(posedge clk);
    #2;
    mask_a = ma;
    mask_b = mb;
    start  = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_idx(input string name, input logic [2:0] target);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (row_idx == target && row_valid) hit = 1'b1;
      else begin
        @(posedge clk);
        #2;
      end
    end
    chk({name, "_reach_idx"}, 32'(hit), 32'd1);
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    chk({name, "_rows_left"}, 32'(row_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (row_valid && out_ready) begin
        if (row_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_row: got idx %0d, required no row", row_idx);
        end else begin
          mon_r = row_q.pop_front();
          $display("row idx=%0d sa=%0b sb=%0b", row_idx, row_sa, row_sb);
          chk("row_idx", 32'(row_idx), 32'(mon_r.idx));
          chk("row_sa", 32'(row_sa), 32'(mon_r.sa));
          chk("row_sb", 32'(row_sb), 32'(mon_r.sb));
        end
      end
      if (done) begin
        if (res_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done: got done=1, required done=0");
        end else begin
          mon_s = res_q.pop_front();
          $display("done equal=%0b count=%0d first=%0d", equal, mismatch_count, first_mismatch);
          chk("done_equal", 32'(equal), 32'(mon_s.eq));
          chk("done_count", 32'(mismatch_count), 32'(mon_s.cnt));
          chk("done_first", 32'(first_mismatch), 32'(mon_s.first));
          chk("done_row_valid", 32'(row_valid), 32'd0);
        end
      end
    end
  end

  task automatic chk_reset_vals(input string name);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_row_valid"}, 32'(row_valid), 32'd0);
    chk({name, "_done"}, 32'(done), 32'd0);
    chk({name, "_row_idx"}, 32'(row_idx), 32'd0);
    chk({name, "_count"}, 32'(mismatch_count), 32'd0);
    chk({name, "_first"}, 32'(first_mismatch), 32'd0);
    chk({name, "_equal"}, 32'(equal), 32'd1);
  endtask

  initial begin
    bit seen4;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1; mask_a = '0; mask_b = '0;
    start4 = 1'b0; out_ready4 = 1'b1; mask_a4 = '0; mask_b4 = '0;
    #2;
    chk_reset_vals("reset");
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Identical functions M(1,2,3,6).
    push_exp(8'b1011_0001, 8'b1011_0001, 1'b1, 4'd0, 3'd0);
    start_sweep(8'b0100_1110, 8'b0100_1110);
    wait_done("same");

    // B lacks M(1): single disagreement at row 1; results must hold afterwards.
    push_exp(8'b1011_0001, 8'b1011_0011, 1'b0, 4'd1, 3'd1);
    start_sweep(8'b0100_1110, 8'b0100_1100);
    wait_done("diff");
    repeat (3) @(posedge clk);
    #2;
    chk("hold_equal", 32'(equal), 32'd0);
    chk("hold_count", 32'(mismatch_count), 32'd1);
    chk("hold_first", 32'(first_mismatch), 32'd1);

    // Stall three cycles on row 2.
    push_exp(8'b1011_0001, 8'b1011_0001, 1'b1, 4'd0, 3'd0);
    start_sweep(8'b0100_1110, 8'b0100_1110);
    wait_idx("stall", 3'd2);
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_idx", 32'(row_idx), 32'd2);
      chk("stall_sa", 32'(row_sa), 32'd0);
      chk("stall_valid", 32'(row_valid), 32'd1);
    end
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_done("stall");

    // Reset in the middle of a sweep at row 4, then a clean sweep.
    push_exp(8'b1011_0001, 8'b1011_0001, 1'b1, 4'd0, 3'd0);
    start_sweep(8'b0100_1110, 8'b0100_1110);
    wait_idx("abort", 3'd4);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("abort");
    row_q.delete();
    res_q.delete();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    push_exp(8'b1011_0001, 8'b1011_0011, 1'b0, 4'd1, 3'd1);
    start_sweep(8'b0100_1110, 8'b0100_1100);
    wait_done("after_abort");

    // A start with different masks mid-sweep must not disturb the sweep.
    push_exp(8'b1011_0001, 8'b1011_0001, 1'b1, 4'd0, 3'd0);
    start_sweep(8'b0100_1110, 8'b0100_1110);
    wait_idx("midstart", 3'd3);
    mask_a = 8'h00;
    mask_b = 8'hFF;
    start  = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_done("midstart");

    // Start raised during the done cycle is ignored.
    push_exp(8'b1011_0001, 8'b1011_0011, 1'b0, 4'd1, 3'd1);
    start_sweep(8'b0100_1110, 8'b0100_1100);
    wait_idx("donestart", 3'd7);
    @(posedge clk);
    #2;
    chk("donestart_in_done", 32'(done), 32'd1);
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    chk("donestart_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #2;
    chk("donestart_busy2", 32'(busy), 32'd0);
    chk("donestart_rows_left", 32'(row_q.size()), 32'd0);

    // N=4: every row disagrees.
    @(posedge clk);
    #2;
    mask_a4 = 16'hFFFF;
    mask_b4 = 16'h0000;
    start4  = 1'b1;
    @(posedge clk);
    #2;
    start4 = 1'b0;
    seen4 = 1'b0;
    for (int i = 0; i < 40 && !seen4; i++) begin
      @(negedge clk);
      if (done4) seen4 = 1'b1;
    end
    $display("n4 done=%0b equal=%0b count=%0d first=%0d", seen4, equal4, mismatch_count4, first_mismatch4);
    chk("n4_done_seen", 32'(seen4), 32'd1);
    chk("n4_count", 32'(mismatch_count4), 32'd16);
    chk("n4_first", 32'(first_mismatch4), 32'd0);
    chk("n4_equal", 32'(equal4), 32'd0);
    chk("n4_row_idx_parked", 32'(row_idx4), 32'd15);

    @(posedge clk);
    #2;
    chk("final_rows_left", 32'(row_q.size()), 32'd0);
    chk("final_results_left", 32'(res_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
